// File: rtl/sharp_display_pkg.sv
// Geometry and per-line phase offsets for the 240x320 Sharp colour memory LCD driver.
package sharp_display_pkg;
  localparam int H_WORDS     = 120;
  localparam int V_ROWS      = 320;
  localparam int TOTAL_LINES = V_ROWS + 2;
  localparam int LINE_CLKS   = 512;

  localparam int RD_OFS    = 4;
  localparam int PIX_OFS   = RD_OFS + 3;
  localparam int BCK_OFS   = 8;
  localparam int BSP_START = 6;
  localparam int BSP_END   = 9;
  localparam int GSP_MID   = 256;
  localparam int GEN_START = 128;
  localparam int GEN_END   = 383;

  localparam logic [8:0] LAST_CLK = 9'(LINE_CLKS - 1);
  localparam logic [8:0] RD_LAST  = 9'(RD_OFS + 4 * (H_WORDS - 1));
  localparam logic [8:0] PIX_LAST = 9'(PIX_OFS + 4 * H_WORDS - 1);
  localparam logic [8:0] BCK_LAST = 9'(BCK_OFS + 4 * (H_WORDS - 1) + 1);

  function automatic logic in_window(input logic [8:0] c, input logic [8:0] lo,
                                     input logic [8:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction
endpackage

// File: rtl/sharp_display_timing_gen.sv
// Line/clock-in-line counters and phase strobes. Strobes describe the position the
// counters move to at the next edge, so the top can register them straight onto the pins.
module sharp_display_timing_gen
  import sharp_display_pkg::*;
#(
  parameter int ROWS = V_ROWS
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [8:0] o_line,
  output logic       o_frame_start,
  output logic       o_rd_stb,
  output logic [6:0] o_word,
  output logic       o_pix_en,
  output logic       o_pix_odd,
  output logic       o_bck,
  output logic       o_bsp,
  output logic       o_gsp,
  output logic       o_gck_tgl,
  output logic       o_gen
);
  localparam logic [8:0] ROWS_L    = 9'(ROWS);
  localparam logic [8:0] LAST_LINE = 9'(ROWS + 1);

  logic       r_run;
  logic [8:0] r_line;
  logic [8:0] r_clk;
  logic [8:0] w_line;
  logic [8:0] w_clk;
  logic       w_active;
  logic [8:0] w_rd_ofs;
  logic [1:0] w_bck_ph;
  logic [1:0] w_pix_ph;

  // First edge out of reset lands on line 0, c=0 rather than c=1.
  always_comb begin
    w_line = r_line;
    w_clk  = r_clk + 9'd1;
    if (!r_run) begin
      w_line = '0;
      w_clk  = '0;
    end else if (r_clk == LAST_CLK) begin
      w_clk  = '0;
      w_line = (r_line == LAST_LINE) ? '0 : r_line + 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_run  <= 1'b0;
      r_line <= '0;
      r_clk  <= '0;
    end else begin
      r_run  <= 1'b1;
      r_line <= w_line;
      r_clk  <= w_clk;
    end
  end

  assign w_active = w_line < ROWS_L;
  assign w_rd_ofs = w_clk - 9'(RD_OFS);
  assign w_bck_ph = w_clk[1:0] - 2'(BCK_OFS);
  assign w_pix_ph = w_clk[1:0] - 2'(PIX_OFS);

  assign o_line        = w_line;
  assign o_frame_start = (w_line == '0) && (w_clk == '0);
  assign o_rd_stb      = w_active && in_window(w_clk, 9'(RD_OFS), RD_LAST)
                         && (w_rd_ofs[1:0] == 2'd0);
  assign o_word        = w_rd_ofs[8:2];
  assign o_pix_en      = w_active && in_window(w_clk, 9'(PIX_OFS), PIX_LAST);
  assign o_pix_odd     = w_pix_ph >= 2'd2;
  assign o_bck         = w_active && in_window(w_clk, 9'(BCK_OFS), BCK_LAST)
                         && (w_bck_ph < 2'd2);
  assign o_bsp         = w_active && in_window(w_clk, 9'(BSP_START), 9'(BSP_END));
  assign o_gsp         = ((w_line == 9'd0) && (w_clk >= 9'(GSP_MID)))
                         || ((w_line == 9'd1) && (w_clk < 9'(GSP_MID)));
  assign o_gck_tgl     = (w_clk == '0) && (w_line != '0);
  assign o_gen         = (w_line != '0) && (w_line <= ROWS_L)
                         && in_window(w_clk, 9'(GEN_START), 9'(GEN_END));
endmodule

// File: rtl/sharp_color_memory_display_driver.sv
// Continuous-refresh driver for a Sharp 64-colour memory LCD: frame-buffer fetch,
// pixel mux and registered panel pins.
module sharp_color_memory_display_driver
  import sharp_display_pkg::*;
#(
  parameter int ROWS = V_ROWS
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        vsync_o,
  output logic [15:0] addr_o,
  output logic        read_valid_o,
  input  logic [15:0] pixel_data_i,
  output logic        intb_o,
  output logic        bsp_o,
  output logic        bck_o,
  output logic        gsp_o,
  output logic        gck_o,
  output logic        gen_o,
  output logic        vcom_o,
  output logic        va_o,
  output logic        vb_o,
  output logic [1:0]  r_o,
  output logic [1:0]  g_o,
  output logic [1:0]  b_o
);
  logic [8:0] w_line;
  logic       w_frame_start;
  logic       w_rd_stb;
  logic [6:0] w_word;
  logic       w_pix_en;
  logic       w_pix_odd;
  logic       w_bck;
  logic       w_bsp;
  logic       w_gsp;
  logic       w_gck_tgl;
  logic       w_gen;
  logic       w_vcom_nxt;
  logic [5:0] w_pix;
  logic       w_unused_bits;

  logic        r_vsync, r_read_valid, r_cap, r_intb, r_bsp, r_bck, r_gsp, r_gck, r_gen;
  logic        r_vcom, r_va, r_vb;
  logic [15:0] r_addr;
  logic [5:0]  r_even, r_odd, r_rgb;

  sharp_display_timing_gen #(.ROWS(ROWS)) u_timing (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .o_line       (w_line),
    .o_frame_start(w_frame_start),
    .o_rd_stb     (w_rd_stb),
    .o_word       (w_word),
    .o_pix_en     (w_pix_en),
    .o_pix_odd    (w_pix_odd),
    .o_bck        (w_bck),
    .o_bsp        (w_bsp),
    .o_gsp        (w_gsp),
    .o_gck_tgl    (w_gck_tgl),
    .o_gen        (w_gen)
  );

  assign w_vcom_nxt    = r_vcom ^ w_frame_start;
  assign w_pix         = w_pix_odd ? r_odd : r_even;
  assign w_unused_bits = ^{pixel_data_i[15:14], pixel_data_i[7:6]};

  // r_cap marks the cycle after a read strobe, when the memory presents the word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vsync      <= 1'b0;
      r_addr       <= '0;
      r_read_valid <= 1'b0;
      r_cap        <= 1'b0;
      r_even       <= '0;
      r_odd        <= '0;
      r_intb       <= 1'b0;
      r_bsp        <= 1'b0;
      r_bck        <= 1'b0;
      r_gsp        <= 1'b0;
      r_gck        <= 1'b0;
      r_gen        <= 1'b0;
      r_vcom       <= 1'b0;
      r_va         <= 1'b0;
      r_vb         <= 1'b0;
      r_rgb        <= '0;
    end else begin
      r_vsync      <= w_frame_start;
      r_read_valid <= w_rd_stb;
      if (w_rd_stb) r_addr <= {w_line, w_word};
      r_cap        <= r_read_valid;
      if (r_cap) begin
        r_even <= pixel_data_i[13:8];
        r_odd  <= pixel_data_i[5:0];
      end
      r_intb <= 1'b1;
      r_bsp  <= w_bsp;
      r_bck  <= w_bck;
      r_gsp  <= w_gsp;
      r_gen  <= w_gen;
      if (w_frame_start)  r_gck <= 1'b0;
      else if (w_gck_tgl) r_gck <= ~r_gck;
      r_vcom <= w_vcom_nxt;
      r_va   <= w_vcom_nxt;
      r_vb   <= ~w_vcom_nxt;
      r_rgb  <= w_pix_en ? w_pix : 6'd0;
    end
  end

  assign vsync_o      = r_vsync;
  assign addr_o       = r_addr;
  assign read_valid_o = r_read_valid;
  assign intb_o       = r_intb;
  assign bsp_o        = r_bsp;
  assign bck_o        = r_bck;
  assign gsp_o        = r_gsp;
  assign gck_o        = r_gck;
  assign gen_o        = r_gen;
  assign vcom_o       = r_vcom;
  assign va_o         = r_va;
  assign vb_o         = r_vb;
  assign r_o          = r_rgb[5:4];
  assign g_o          = r_rgb[3:2];
  assign b_o          = r_rgb[1:0];
endmodule

// File: tb/tb_sharp_color_memory_display_driver.sv
// Directed bench for the Sharp colour memory LCD driver: full-size instance for line
// timing and fetch data, a 4-row instance for whole-frame sequencing.
`timescale 1ns/1ps
module tb_sharp_color_memory_display_driver;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] pixel_data_i = '0;
  logic        vsync_o, read_valid_o, intb_o, bsp_o, bck_o, gsp_o, gck_o, gen_o;
  logic        vcom_o, va_o, vb_o;
  logic [15:0] addr_o;
  logic [1:0]  r_o, g_o, b_o;

  logic        s_reset = 1'b1;
  logic [15:0] s_pix = '0;
  logic        s_vsync, s_rv, s_intb, s_bsp, s_bck, s_gsp, s_gck, s_gen, s_vcom, s_va, s_vb;
  logic [15:0] s_addr;
  logic [1:0]  s_r, s_g, s_b;

  int n_checks = 0;
  int n_fail = 0;
  int pos = 0;

  sharp_color_memory_display_driver dut (
    .clk_i(clk_i), .reset_i(reset_i), .vsync_o(vsync_o), .addr_o(addr_o),
    .read_valid_o(read_valid_o), .pixel_data_i(pixel_data_i), .intb_o(intb_o),
    .bsp_o(bsp_o), .bck_o(bck_o), .gsp_o(gsp_o), .gck_o(gck_o), .gen_o(gen_o),
    .vcom_o(vcom_o), .va_o(va_o), .vb_o(vb_o), .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  sharp_color_memory_display_driver #(.ROWS(4)) dut_small (
    .clk_i(clk_i), .reset_i(s_reset), .vsync_o(s_vsync), .addr_o(s_addr),
    .read_valid_o(s_rv), .pixel_data_i(s_pix), .intb_o(s_intb),
    .bsp_o(s_bsp), .bck_o(s_bck), .gsp_o(s_gsp), .gck_o(s_gck), .gen_o(s_gen),
    .vcom_o(s_vcom), .va_o(s_va), .vb_o(s_vb), .r_o(s_r), .g_o(s_g), .b_o(s_b)
  );

  always #42 clk_i = ~clk_i;

  // Row 2 returns a distinct even/odd pattern; every other row returns addr[12:11]
  // in all colour fields. Ignored bits are set to catch slicing errors.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [1:0] f;
    f = a[12:11];
    if (a[15:7] == 9'd2) return 16'b11_01_10_11_11_11_01_10;
    return {2'b11, f, f, f, 2'b11, f, f, f};
  endfunction

  always @(posedge clk_i) if (read_valid_o) pixel_data_i <= mem_word(addr_o);

  function automatic logic [32:0] all_out();
    return {vsync_o, addr_o, read_valid_o, intb_o, bsp_o, bck_o, gsp_o, gck_o, gen_o,
            vcom_o, va_o, vb_o, r_o, g_o, b_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    pos++;
  endtask

  task automatic skip_to(input int target);
    while (pos < target) tick();
  endtask

  // Walks one full line of the full-size instance, starting at c=0.
  task automatic check_line(input int ln, input logic [5:0] ev, input logic [5:0] od,
                            input logic vc, output int n_rd, output int n_bck_rise);
    logic        act, e_vs, e_rv, e_bck, e_bsp, e_gsp, e_gen, e_gck, prev_bck;
    logic [5:0]  e_rgb;
    logic [16:0] exp_v, got_v;
    logic [15:0] e_addr;
    n_rd = 0;
    n_bck_rise = 0;
    prev_bck = 1'b0;
    for (int c = 0; c < 512; c++) begin
      act   = ln < 320;
      e_vs  = (ln == 0) && (c == 0);
      e_rv  = act && c >= 4 && c <= 480 && (c % 4) == 0;
      e_bck = act && c >= 8 && c <= 487 && ((c - 8) % 4) < 2;
      e_bsp = act && c >= 6 && c <= 9;
      e_gsp = ((ln == 0) && c >= 256) || ((ln == 1) && c < 256);
      e_gen = ln >= 1 && ln <= 320 && c >= 128 && c <= 383;
      e_gck = (ln % 2) == 1;
      e_rgb = (act && c >= 7 && c <= 486) ? ((((c - 7) % 4) < 2) ? ev : od) : 6'd0;
      exp_v = {e_vs, e_rv, e_bck, e_bsp, e_gsp, e_gen, e_gck, 1'b1, vc, vc, ~vc, e_rgb};
      got_v = {vsync_o, read_valid_o, bck_o, bsp_o, gsp_o, gen_o, gck_o, intb_o,
               vcom_o, va_o, vb_o, r_o, g_o, b_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL pins line %0d c %0d: got %b expected %b", ln, c, got_v, exp_v);
      end
      if (e_rv) begin
        e_addr = {9'(ln), 7'((c - 4) / 4)};
        n_checks++;
        if (addr_o !== e_addr) begin
          n_fail++;
          $display("FAIL addr line %0d c %0d: got %h expected %h", ln, c, addr_o, e_addr);
        end
      end
      if (read_valid_o === 1'b1) n_rd++;
      if (bck_o === 1'b1 && prev_bck === 1'b0) n_bck_rise++;
      prev_bck = bck_o;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i > 0) begin
        n_checks++;
        if (all_out() !== 33'd0) begin
          n_fail++;
          $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, all_out());
        end
      end
    end
    reset_i = 1'b0;
    tick();
    pos = 0;
    n_checks++;
    if ({vsync_o, intb_o, va_o, vb_o} !== 4'b1110) begin
      n_fail++;
      $display("FAIL first_cycle vsync/intb/va/vb: got %b expected 1110",
               {vsync_o, intb_o, va_o, vb_o});
    end
  endtask

  task automatic test_line0_fetch();
    int n_rd, n_rise;
    check_line(0, 6'd0, 6'd0, 1'b1, n_rd, n_rise);
    n_checks++;
    if (n_rd !== 120) begin
      n_fail++;
      $display("FAIL line0_reads: got %0d expected 120", n_rd);
    end
    n_checks++;
    if (n_rise !== 120) begin
      n_fail++;
      $display("FAIL line0_bck_edges: got %0d expected 120", n_rise);
    end
  endtask

  task automatic test_gate_and_pixel_order();
    int n_rd, n_rise;
    check_line(1, 6'd0, 6'd0, 1'b1, n_rd, n_rise);
    check_line(2, 6'b01_10_11, 6'b11_01_10, 1'b1, n_rd, n_rise);
  endtask

  task automatic test_pixel_rows();
    int n_rd, n_rise;
    skip_to(15 * 512);
    check_line(15, 6'd0, 6'd0, 1'b1, n_rd, n_rise);
    check_line(16, 6'b01_01_01, 6'b01_01_01, 1'b1, n_rd, n_rise);
    skip_to(48 * 512);
    check_line(48, 6'b11_11_11, 6'b11_11_11, 1'b1, n_rd, n_rise);
  endtask

  task automatic test_mid_reset();
    int n_rd, n_rise;
    skip_to(100 * 512 + 300);
    reset_i = 1'b1;
    tick();
    n_checks++;
    if (all_out() !== 33'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0", all_out());
    end
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    pos = 0;
    check_line(0, 6'd0, 6'd0, 1'b1, n_rd, n_rise);
    n_checks++;
    if (n_rd !== 120) begin
      n_fail++;
      $display("FAIL restart_reads: got %0d expected 120", n_rd);
    end
  endtask

  // 4-row instance: 6 lines per frame, 3072 clocks.
  task automatic test_small_frame();
    int vs_mid = 0, gck_tg = 0, gen_p = 0, gen_hi = 0, tail_act = 0, gen_l4 = 0, rd_act = 0;
    logic prev_gck = 1'b0, prev_gen = 1'b0;
    int ln;
    s_reset = 1'b0;
    tick();
    n_checks++;
    if ({s_vsync, s_vcom, s_va, s_vb, s_gck} !== 5'b11100) begin
      n_fail++;
      $display("FAIL small_first: got %b expected 11100", {s_vsync, s_vcom, s_va, s_vb, s_gck});
    end
    for (int n = 0; n < 3072; n++) begin
      ln = n / 512;
      if (n > 0) begin
        vs_mid += int'(s_vsync);
        if (s_gck !== prev_gck) gck_tg++;
      end
      if (s_gen && !prev_gen) gen_p++;
      gen_hi += int'(s_gen);
      if (ln >= 4) tail_act += int'(s_rv) + int'(s_bck) + int'(s_bsp);
      else rd_act += int'(s_rv);
      if (ln == 4) gen_l4 += int'(s_gen);
      prev_gck = s_gck;
      prev_gen = s_gen;
      tick();
    end
    n_checks++;
    if (vs_mid !== 0) begin n_fail++; $display("FAIL small_vsync_inside: got %0d expected 0", vs_mid); end
    n_checks++;
    if (gck_tg !== 5) begin n_fail++; $display("FAIL small_gck_toggles: got %0d expected 5", gck_tg); end
    n_checks++;
    if (gen_p !== 4) begin n_fail++; $display("FAIL small_gen_pulses: got %0d expected 4", gen_p); end
    n_checks++;
    if (gen_hi !== 1024) begin n_fail++; $display("FAIL small_gen_clocks: got %0d expected 1024", gen_hi); end
    n_checks++;
    if (gen_l4 !== 256) begin n_fail++; $display("FAIL small_gen_last_line: got %0d expected 256", gen_l4); end
    n_checks++;
    if (tail_act !== 0) begin n_fail++; $display("FAIL small_tail_source: got %0d expected 0", tail_act); end
    n_checks++;
    if (rd_act !== 480) begin n_fail++; $display("FAIL small_reads: got %0d expected 480", rd_act); end
    n_checks++;
    if ({s_vsync, s_vcom, s_va, s_vb, s_gck} !== 5'b10010) begin
      n_fail++;
      $display("FAIL small_second_frame: got %b expected 10010", {s_vsync, s_vcom, s_va, s_vb, s_gck});
    end
  endtask

  initial begin
    test_reset();
    test_line0_fetch();
    test_gate_and_pixel_order();
    test_pixel_rows();
    test_mid_reset();
    test_small_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
